obm_dma_controller: RTL and testbench
=====================================

// Module: obm_dma_controller
// PURPOSE
//  Sequences a 256-byte block copy from CPU work RAM into Object Memory (OBM, VRAM 0x800-0x8FF) during vblank.
//  Shares the single VRAM write port between the CPU and the DMA engine.
//  Sits between the CPU bus decode and foreground_m's VRAM write interface.
//  Lets software refresh all 64 objects atomically per frame without tearing.
// PARAMETERS
//  VRAM_ADDR_WIDTH  12      width of VRAM address bus
//  OBM_BASE         12'h800 VRAM address of OBM byte 0
//  XFER_LEN         256     bytes per transfer (4 bytes x 64 objects); power of 2, <=256
// PORTS
//  gpu_clk          in   1   single clock for all logic
//  rst              in   1   synchronous reset, active-high
//  vblank           in   1   high while the display is outside the visible area
//  start            in   1   one-cycle strobe from CPU register write: arm a transfer
//  src_page         in   8   RAM page of the source; source addr = {src_page, idx}
//  ram_req          out  1   DMA read request to work RAM
//  ram_addr         out  16  RAM read address, valid while ram_req=1
//  ram_gnt          in   1   RAM accepts request this cycle; ram_rdata valid next cycle
//  ram_rdata        in   8   RAM read data
//  cpu_addr         in   VRAM_ADDR_WIDTH  CPU VRAM address
//  cpu_wdata        in   8   CPU VRAM write data
//  cpu_we           in   1   CPU VRAM write enable
//  cpu_sel_pmf      in   1   CPU decode: PMF selected
//  cpu_sel_obm      in   1   CPU decode: OBM selected
//  vram_address     out  VRAM_ADDR_WIDTH  to foreground_m
//  vram_wdata       out  8   to foreground_m data_in
//  vram_we          out  1   to foreground_m write_enable
//  SELECT_pmf       out  1   to foreground_m
//  SELECT_obm       out  1   to foreground_m
//  busy             out  1   state != IDLE
//  done             out  1   one-cycle pulse: transfer completed
//  aborted          out  1   one-cycle pulse: vblank ended mid-transfer
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, hold=0, page=0; ram_req, busy, done and aborted are 0.
//   VRAM outputs are the CPU pass-through.
//  FSM states: IDLE, ARMED, REQ, DATA, WRITE, DONE.
//  IDLE:  start=1 -> latch src_page, idx=0 -> ARMED.
//  ARMED: vblank=1 -> REQ. Otherwise hold in ARMED; this may span frames.
//  REQ:   ram_req=1, ram_addr={page,idx[7:0]}.
//   ram_gnt=1 -> DATA; otherwise hold with request and address stable.
//  DATA:  hold<=ram_rdata -> WRITE.
//  WRITE: cpu_we=1 -> stall in WRITE; the CPU owns the port (CPU priority).
//   cpu_we=0 -> DMA write cycle with vram_address=OBM_BASE+idx, vram_wdata=hold, vram_we=1, SELECT_obm=1, SELECT_pmf=0.
//   If idx==XFER_LEN-1 -> DONE; else idx<=idx+1 -> REQ.
//  DONE:  done=1 for one cycle -> IDLE.
//  Abort: vblank=0 while in REQ/DATA/WRITE -> IDLE next cycle with aborted=1 for one cycle.
//   No VRAM write happens in the abort cycle. Bytes already written stay written.
//   Abort takes precedence over a simultaneous ram_gnt or write.
//  start while busy=1 is ignored; page is not re-latched.
//  VRAM output mux is combinational: DMA drives the port only in a DMA write cycle.
//   All other cycles pass cpu_* straight through, including cycles where DMA is busy but not writing.
//  idx is 8 bits and wraps only via DONE; address arithmetic is VRAM_ADDR_WIDTH wide with carry dropped.
//  Throughput: minimum 3 cycles per byte (REQ, DATA, WRITE) with immediate grant and no CPU stall.
//   A full transfer takes 768 cycles minimum, plus 1 DONE cycle.
// TESTING
//  1. Reset -> busy=0, ram_req=0, vram_we=cpu_we, and all pulses 0.
//  2. start, src_page=0x02, vblank=1, ram_gnt tied 1, RAM[0x0200+i]=i^0xA5
//     -> OBM[i]=i^0xA5 for all i, done after 769 cycles, busy then drops.
//  3. As test 2 with ram_gnt low for 5 cycles at idx=10
//     -> ram_addr holds at 0x020A, no extra writes, data correct.
//  4. cpu_we=1 to PMF addr 0x010 during a DMA WRITE state
//     -> CPU write lands in PMF, DMA stalls 1 cycle, OBM byte still written after.
//  5. Drop vblank at idx=100 -> aborted pulse, busy=0, OBM[0..99] updated, OBM[100..255] unchanged.
//  6. start with vblank=0, a second start with a different page, then vblank rises
//     -> first page is used; done pulses once.

Source files
------------

// File: rtl/obm_dma_controller.sv
// Block-copy engine: moves XFER_LEN bytes from CPU work RAM into Object Memory during vblank,
// sharing the single VRAM write port with the CPU (CPU always wins).
module obm_dma_controller #(
    parameter int                         VRAM_ADDR_WIDTH = 12,
    parameter logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE        = 12'h800,
    parameter int                         XFER_LEN        = 256
) (
    input  logic                       gpu_clk,
    input  logic                       rst,
    input  logic                       vblank,
    input  logic                       start,
    input  logic [7:0]                 src_page,
    output logic                       ram_req,
    output logic [15:0]                ram_addr,
    input  logic                       ram_gnt,
    input  logic [7:0]                 ram_rdata,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]                 cpu_wdata,
    input  logic                       cpu_we,
    input  logic                       cpu_sel_pmf,
    input  logic                       cpu_sel_obm,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]                 vram_wdata,
    output logic                       vram_we,
    output logic                       SELECT_pmf,
    output logic                       SELECT_obm,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_REQ   = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state_r, state_s;
    logic [7:0] idx_r, idx_s;
    logic [7:0] hold_r, hold_s;
    logic [7:0] page_r, page_s;
    logic       aborted_r;
    logic       abort_s;
    logic       dma_wr_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 8'd0;
            hold_r    <= 8'd0;
            page_r    <= 8'd0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            hold_r    <= hold_s;
            page_r    <= page_s;
            aborted_r <= abort_s;
        end
    end

    // Next-state logic; losing vblank mid-copy overrides grant and write.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        hold_s   = hold_r;
        page_s   = page_r;
        abort_s  = 1'b0;
        dma_wr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    page_s  = src_page;
                    idx_s   = 8'd0;
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (vblank) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_REQ: begin
                if (!vblank) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (ram_gnt) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (!vblank) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    hold_s  = ram_rdata;
                    state_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!vblank) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (cpu_we) begin
                    state_s = ST_WRITE;
                end else begin
                    dma_wr_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = idx_r + 8'd1;
                        state_s = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // VRAM port mux: DMA owns the port only during its own write cycle.
    always_comb begin
        if (dma_wr_s) begin
            vram_address = OBM_BASE + VRAM_ADDR_WIDTH'(idx_r);
            vram_wdata   = hold_r;
            vram_we      = 1'b1;
            SELECT_obm   = 1'b1;
            SELECT_pmf   = 1'b0;
        end else begin
            vram_address = cpu_addr;
            vram_wdata   = cpu_wdata;
            vram_we      = cpu_we;
            SELECT_obm   = cpu_sel_obm;
            SELECT_pmf   = cpu_sel_pmf;
        end
    end

    assign ram_req  = (state_r == ST_REQ);
    assign ram_addr = {page_r, idx_r};
    assign busy     = (state_r != ST_IDLE);
    assign done     = (state_r == ST_DONE);
    assign aborted  = aborted_r;

endmodule

// File: tb/tb_obm_dma_controller.sv
// Directed and randomized bench for obm_dma_controller: RAM/VRAM models plus a transfer-level
// reference (expected OBM image, byte-write count, completion cycle).
module tb_obm_dma_controller;

    logic        gpu_clk = 1'b0;
    logic        rst, vblank, start, ram_gnt, cpu_we, cpu_sel_pmf, cpu_sel_obm;
    logic [7:0]  src_page, ram_rdata, cpu_wdata, vram_wdata;
    logic        ram_req, vram_we, SELECT_pmf, SELECT_obm, busy, done, aborted;
    logic [15:0] ram_addr;
    logic [11:0] cpu_addr, vram_address;

    obm_dma_controller dut (
        .gpu_clk(gpu_clk), .rst(rst), .vblank(vblank), .start(start), .src_page(src_page),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_gnt(ram_gnt), .ram_rdata(ram_rdata),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_sel_pmf(cpu_sel_pmf), .cpu_sel_obm(cpu_sel_obm),
        .vram_address(vram_address), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .SELECT_pmf(SELECT_pmf), .SELECT_obm(SELECT_obm),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 gpu_clk = ~gpu_clk;

    logic [7:0] mem     [0:65535];
    logic [7:0] obm_mem [0:255];
    logic [7:0] obm_exp [0:255];
    logic [7:0] pmf_mem [0:4095];
    logic [7:0] pmf_exp [0:4095];
    int         obm_wr_cnt = 0;

    // Work RAM (one-cycle read latency after grant) and VRAM destination models.
    always @(posedge gpu_clk) begin
        if (ram_req && ram_gnt) ram_rdata <= mem[ram_addr];
        if (vram_we && SELECT_obm) begin
            obm_wr_cnt = obm_wr_cnt + 1;
            if (vram_address >= 12'h800 && vram_address < 12'h900) obm_mem[vram_address[7:0]] = vram_wdata;
        end
        if (vram_we && SELECT_pmf) pmf_mem[vram_address] = vram_wdata;
    end

    int checks = 0, errors = 0;
    int gnt_prob, stall_left, cpu_k, cpu_prob, abort_at, probe_k;
    int done_cnt, done_k, abort_k, wr0;
    logic [15:0] stall_addr, first_addr;
    logic [11:0] probe_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic policy_default();
        gnt_prob = 100; stall_left = 0; stall_addr = 16'h0000; cpu_k = -1; cpu_prob = 0;
        abort_at = -1; probe_k = -1; probe_addr = 12'h000;
    endtask

    task automatic fill_page(input logic [7:0] page);
        for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'($urandom);
    endtask

    // Snapshot destination state so the reference only has to describe what changes.
    task automatic begin_xfer();
        obm_exp = obm_mem;
        pmf_exp = pmf_mem;
        wr0     = obm_wr_cnt;
    endtask

    task automatic expect_bytes(input logic [7:0] page, input int n);
        for (int i = 0; i < n; i++) obm_exp[i] = mem[{page, 8'(i)}];
    endtask

    task automatic check_dest(input string tag, input int n_writes);
        int bad_obm = 0, bad_pmf = 0;
        for (int i = 0; i < 256; i++) if (obm_mem[i] !== obm_exp[i]) bad_obm++;
        for (int i = 0; i < 4096; i++) if (pmf_mem[i] !== pmf_exp[i]) bad_pmf++;
        chk({tag, "_obm_data"}, bad_obm, 0);
        chk({tag, "_pmf_data"}, bad_pmf, 0);
        chk({tag, "_obm_writes"}, obm_wr_cnt - wr0, n_writes);
    endtask

    task automatic kick(input logic [7:0] page);
        @(negedge gpu_clk);
        start = 1'b1; src_page = page;
    endtask

    // Drive one transfer to completion or abort; k counts edges since the start strobe.
    task automatic run(input int budget);
        bit fin = 1'b0, stall_on = 1'b0, seen_req = 1'b0;
        done_cnt = 0; done_k = -1; abort_k = -1; first_addr = 16'hFFFF;
        for (int k = 0; k < budget && !fin; k++) begin
            @(negedge gpu_clk);
            start = 1'b0;
            if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (aborted && abort_k < 0) abort_k = k;
            if (ram_req && !seen_req) begin seen_req = 1'b1; first_addr = ram_addr; end
            if (!busy && (done_k >= 0 || abort_k >= 0)) fin = 1'b1;
            if (k == abort_at) vblank = 1'b0;
            ram_gnt = ($urandom_range(0, 99) < gnt_prob);
            if (stall_left > 0 && (stall_on || (ram_req && ram_addr == stall_addr))) begin
                stall_on = 1'b1;
                chk("stall_req", ram_req, 1);
                chk("stall_addr", ram_addr, stall_addr);
                ram_gnt = 1'b0;
                stall_left--;
            end
            cpu_we = 1'b0; cpu_sel_pmf = 1'b0;
            if (k == cpu_k || (cpu_prob > 0 && $urandom_range(0, 99) < cpu_prob)) begin
                cpu_addr    = (k == cpu_k) ? 12'h010 : 12'($urandom_range(0, 2047));
                cpu_wdata   = (k == cpu_k) ? 8'h5C : 8'($urandom);
                cpu_we      = 1'b1;
                cpu_sel_pmf = 1'b1;
                pmf_exp[cpu_addr] = cpu_wdata;
                #1;
                chk("cpu_pass", {vram_we, SELECT_pmf, SELECT_obm, vram_address, vram_wdata},
                    {1'b1, 1'b1, 1'b0, cpu_addr, cpu_wdata});
            end
            if (k == probe_k) begin
                #1;
                chk("dma_write_after_stall", {vram_we, SELECT_obm, SELECT_pmf, vram_address},
                    {1'b1, 1'b1, 1'b0, probe_addr});
            end
        end
        if (!fin) chk("run_timeout", 0, 1);
        @(negedge gpu_clk);
        cpu_we = 1'b0; cpu_sel_pmf = 1'b0;
        chk("pulses_low_after", {done, aborted, busy}, 3'b000);
    endtask

    initial begin
        int j, p;
        rst = 1'b1; vblank = 1'b0; start = 1'b0; src_page = 8'h00; ram_gnt = 1'b0;
        cpu_addr = 12'h123; cpu_wdata = 8'h77; cpu_we = 1'b1; cpu_sel_pmf = 1'b0; cpu_sel_obm = 1'b0;
        policy_default();
        repeat (3) @(negedge gpu_clk);
        chk("reset_status", {busy, ram_req, done, aborted}, 4'b0000);
        chk("reset_passthrough", {vram_we, vram_address, vram_wdata}, {1'b1, 12'h123, 8'h77});
        cpu_we = 1'b0;
        #1 chk("reset_passthrough_we0", vram_we, 0);
        @(negedge gpu_clk);
        rst = 1'b0;

        // Full copy, immediate grant: done at edge 769.
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        vblank = 1'b1; begin_xfer(); expect_bytes(8'h02, 256);
        kick(8'h02); run(2000);
        chk("full_done_cycle", done_k, 769);
        chk("full_done_count", done_cnt, 1);
        check_dest("full", 256);

        // Grant withheld for 5 cycles at idx 10.
        fill_page(8'h03); begin_xfer(); expect_bytes(8'h03, 256);
        stall_addr = 16'h030A; stall_left = 5;
        kick(8'h03); run(2000);
        chk("stall_used", stall_left, 0);
        chk("stall_done_cycle", done_k, 774);
        check_dest("stall", 256);
        policy_default();

        // CPU PMF write lands during the WRITE cycle of idx 20; DMA writes 0x814 next cycle.
        fill_page(8'h04); begin_xfer(); expect_bytes(8'h04, 256);
        cpu_k = 63; probe_k = 64; probe_addr = 12'h814;
        kick(8'h04); run(2000);
        chk("cpu_stall_done_cycle", done_k, 770);
        check_dest("cpu_prio", 256);
        policy_default();

        // vblank lost in REQ of idx 100.
        fill_page(8'h05); begin_xfer(); expect_bytes(8'h05, 100);
        abort_at = 301;
        kick(8'h05); run(2000);
        chk("abort_cycle", abort_k, 302);
        chk("abort_no_done", done_cnt, 0);
        check_dest("abort100", 100);
        policy_default();

        // Randomized abort point and phase (REQ/DATA/WRITE).
        for (int r = 0; r < 3; r++) begin
            j = $urandom_range(1, 254); p = $urandom_range(0, 2);
            vblank = 1'b1;
            fill_page(8'h06); begin_xfer(); expect_bytes(8'h06, j);
            abort_at = 3 * j + 1 + p;
            kick(8'h06); run(2000);
            chk("rand_abort_cycle", abort_k, abort_at + 1);
            check_dest("rand_abort", j);
            policy_default();
        end

        // Arm outside vblank; a second start with another page is ignored.
        fill_page(8'h33);
        for (int i = 0; i < 256; i++) mem[{8'h44, 8'(i)}] = ~mem[{8'h33, 8'(i)}];
        vblank = 1'b0; begin_xfer(); expect_bytes(8'h33, 256);
        kick(8'h33);
        @(negedge gpu_clk); start = 1'b0;
        repeat (4) @(negedge gpu_clk);
        chk("armed_wait", {busy, ram_req}, 2'b10);
        start = 1'b1; src_page = 8'h44;
        @(negedge gpu_clk); start = 1'b0;
        vblank = 1'b1;
        run(2000);
        chk("armed_first_addr", first_addr, 16'h3300);
        chk("armed_done_count", done_cnt, 1);
        check_dest("armed", 256);

        // Randomized grants and CPU PMF traffic.
        for (int r = 0; r < 2; r++) begin
            logic [7:0] pg;
            pg = 8'($urandom_range(16'h40, 16'h7F));
            fill_page(pg); begin_xfer(); expect_bytes(pg, 256);
            gnt_prob = 60; cpu_prob = 15;
            kick(pg); run(5000);
            chk("rand_done_count", done_cnt, 1);
            check_dest("rand_xfer", 256);
            policy_default();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
